cpu_controller: RTL

Instruction register, decoder and sequencing FSM that drives every control input of the Simple RISC Machine datapath. It accepts a 16-bit instruction on a start strobe and decodes it. It then walks the datapath through register read, ALU execute and write-back, one micro-step per clock. It reports completion by returning to its wait state.

---
 rtl/cpu_pkg.sv | 67 ++++++
 rtl/cpu_controller_if.sv | 41 ++++
 rtl/cpu_controller_instr_decoder.sv | 47 ++++
 rtl/cpu_controller.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the Simple RISC Machine controller.
// Holds the FSM state enum, instruction opcode/op constants, ALU operation
// codes, the one-hot write-back selects, the register-index select encodings
// and the immediate sign-extension helpers.
package cpu_pkg;

    // Sequencing FSM states
    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_GET_A     = 3'd2,
        ST_GET_B     = 3'd3,
        ST_EXEC      = 3'd4,
        ST_WRITE_REG = 3'd5,
        ST_WRITE_IMM = 3'd6
    } state_t;

    // Decoded instruction classes
    typedef enum logic [2:0] {
        CLS_UNDEF   = 3'd0,
        CLS_MOV_IMM = 3'd1,
        CLS_MOV_REG = 3'd2,
        CLS_ADD     = 3'd3,
        CLS_CMP     = 3'd4,
        CLS_AND     = 3'd5,
        CLS_MVN     = 3'd6
    } instr_class_t;

    // Opcode field values [15:13]
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // Op field values [12:11]
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    // ALU operation codes
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    // One-hot write-back selects
    localparam logic [3:0] VSEL_MDATA = 4'b1000;
    localparam logic [3:0] VSEL_IMM8  = 4'b0100;
    localparam logic [3:0] VSEL_PC    = 4'b0010;
    localparam logic [3:0] VSEL_C     = 4'b0001;

    // Register index select (one-hot, all-zero drives index 0)
    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b100;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b001;

    function automatic logic [15:0] sign_extend5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

    function automatic logic [15:0] sign_extend8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// cpu_controller_if: bundle of the controller's instruction handshake and all
// datapath control outputs.
//   s, in              : start strobe and instruction word (master -> slave)
//   w                  : ready/waiting flag
//   readnum, writenum  : register indices
//   write, vsel        : register file write enable and write-back select
//   loada/b/c/s        : datapath register enables
//   asel, bsel, shift  : operand steering
//   ALUop              : ALU operation
//   sximm5, sximm8     : sign-extended immediates from the IR
interface cpu_controller_if;
    logic        s;
    logic [15:0] in;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [3:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm5;
    logic [15:0] sximm8;

    modport master (
        output s, in,
        input  w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
               asel, bsel, shift, ALUop, sximm5, sximm8
    );

    modport slave (
        input  s, in,
        output w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
               asel, bsel, shift, ALUop, sximm5, sximm8
    );
endinterface

// File: rtl/cpu_controller_instr_decoder.sv
// instr_decoder: purely combinational split of the instruction register into
// register fields, shift amount, sign-extended immediates and an instruction
// class used by the sequencing FSM.
//   i_ir       : instruction register contents
//   o_rn/rd/rm : register index fields
//   o_shift    : IR[4:3]
//   o_op       : IR[12:11]
//   o_sximm5/8 : sign-extended immediates
//   o_class    : decoded instruction class
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0]  i_ir,
    output logic [2:0]   o_rn,
    output logic [2:0]   o_rd,
    output logic [2:0]   o_rm,
    output logic [1:0]   o_shift,
    output logic [1:0]   o_op,
    output logic [15:0]  o_sximm5,
    output logic [15:0]  o_sximm8,
    output instr_class_t o_class
);
    logic [2:0] w_opcode;

    assign w_opcode = i_ir[15:13];
    assign o_op     = i_ir[12:11];
    assign o_rn     = i_ir[10:8];
    assign o_rd     = i_ir[7:5];
    assign o_shift  = i_ir[4:3];
    assign o_rm     = i_ir[2:0];
    assign o_sximm5 = sign_extend5(i_ir[4:0]);
    assign o_sximm8 = sign_extend8(i_ir[7:0]);

    // Opcode/op pair to instruction class
    always_comb begin
        o_class = CLS_UNDEF;
        case ({w_opcode, o_op})
            {OPC_MOV, OP_MOV_IMM}: o_class = CLS_MOV_IMM;
            {OPC_MOV, OP_MOV_REG}: o_class = CLS_MOV_REG;
            {OPC_ALU, OP_ADD}:     o_class = CLS_ADD;
            {OPC_ALU, OP_CMP}:     o_class = CLS_CMP;
            {OPC_ALU, OP_AND}:     o_class = CLS_AND;
            {OPC_ALU, OP_MVN}:     o_class = CLS_MVN;
            default:               o_class = CLS_UNDEF;
        endcase
    end
endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: instruction register plus sequencing FSM that drives the
// Simple RISC Machine datapath one micro-step per clock.
//   clk    : system clock, rising edge
//   resetn : synchronous active-low reset
//   bus    : slave side of cpu_controller_if (start/instruction in,
//            all datapath controls out)
// All outputs depend only on the state and IR registers.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    cpu_controller_if.slave   bus
);
    state_t       r_state;
    state_t       w_next_state;
    logic [15:0]  r_ir;

    logic [2:0]   w_rn;
    logic [2:0]   w_rd;
    logic [2:0]   w_rm;
    logic [1:0]   w_ir_shift;
    logic [1:0]   w_op;
    logic [15:0]  w_sximm5;
    logic [15:0]  w_sximm8;
    instr_class_t w_class;

    logic [2:0]   w_nsel;
    logic [2:0]   w_regnum;
    logic         w_w;
    logic         w_write;
    logic [3:0]   w_vsel;
    logic         w_loada;
    logic         w_loadb;
    logic         w_loadc;
    logic         w_loads;
    logic         w_asel;
    logic         w_bsel;
    logic [1:0]   w_shift;
    logic [1:0]   w_aluop;

    instr_decoder u_decoder (
        .i_ir     (r_ir),
        .o_rn     (w_rn),
        .o_rd     (w_rd),
        .o_rm     (w_rm),
        .o_shift  (w_ir_shift),
        .o_op     (w_op),
        .o_sximm5 (w_sximm5),
        .o_sximm8 (w_sximm8),
        .o_class  (w_class)
    );

    // State register and instruction capture; IR only loads on an accepted start
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_WAIT;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_next_state;
            if ((r_state == ST_WAIT) && bus.s) begin
                r_ir <= bus.in;
            end
        end
    end

    // Next-state sequencing
    always_comb begin
        w_next_state = ST_WAIT;
        case (r_state)
            ST_WAIT: begin
                if (bus.s) begin
                    w_next_state = ST_DECODE;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_DECODE: begin
                case (w_class)
                    CLS_MOV_IMM:                 w_next_state = ST_WRITE_IMM;
                    CLS_MOV_REG, CLS_MVN:        w_next_state = ST_GET_B;
                    CLS_ADD, CLS_CMP, CLS_AND:   w_next_state = ST_GET_A;
                    default:                     w_next_state = ST_WAIT;
                endcase
            end
            ST_GET_A: w_next_state = ST_GET_B;
            ST_GET_B: w_next_state = ST_EXEC;
            ST_EXEC: begin
                if (w_class == CLS_CMP) begin
                    w_next_state = ST_WAIT;
                end else begin
                    w_next_state = ST_WRITE_REG;
                end
            end
            ST_WRITE_REG: w_next_state = ST_WAIT;
            ST_WRITE_IMM: w_next_state = ST_WAIT;
            default:      w_next_state = ST_WAIT;
        endcase
    end

    // Moore output decode; vsel rests at the C select outside WRITE_IMM
    always_comb begin
        w_w     = 1'b0;
        w_nsel  = NSEL_NONE;
        w_write = 1'b0;
        w_vsel  = VSEL_C;
        w_loada = 1'b0;
        w_loadb = 1'b0;
        w_loadc = 1'b0;
        w_loads = 1'b0;
        w_asel  = 1'b0;
        w_bsel  = 1'b0;
        w_shift = 2'b00;
        w_aluop = ALU_ADD;
        case (r_state)
            ST_WAIT: w_w = 1'b1;
            ST_DECODE: w_w = 1'b0;
            ST_GET_A: begin
                w_nsel  = NSEL_RN;
                w_loada = 1'b1;
            end
            ST_GET_B: begin
                w_nsel  = NSEL_RM;
                w_loadb = 1'b1;
            end
            ST_EXEC: begin
                // Non-ALU (MOV reg) moves go through the adder with A zeroed
                if (w_class == CLS_MOV_REG) begin
                    w_aluop = ALU_ADD;
                end else begin
                    w_aluop = w_op;
                end
                w_asel = (w_class == CLS_MOV_REG) || (w_class == CLS_MVN);
                // bsel is never set by the supported set; shift is gated for safety
                if (w_bsel) begin
                    w_shift = 2'b00;
                end else begin
                    w_shift = w_ir_shift;
                end
                if (w_class == CLS_CMP) begin
                    w_loads = 1'b1;
                end else begin
                    w_loadc = 1'b1;
                end
            end
            ST_WRITE_REG: begin
                w_nsel  = NSEL_RD;
                w_vsel  = VSEL_C;
                w_write = 1'b1;
            end
            ST_WRITE_IMM: begin
                w_nsel  = NSEL_RN;
                w_vsel  = VSEL_IMM8;
                w_write = 1'b1;
            end
            default: w_w = 1'b0;
        endcase
    end

    // Register-index mux shared by readnum and writenum
    always_comb begin
        w_regnum = 3'd0;
        case (w_nsel)
            NSEL_RN: w_regnum = w_rn;
            NSEL_RD: w_regnum = w_rd;
            NSEL_RM: w_regnum = w_rm;
            default: w_regnum = 3'd0;
        endcase
    end

    assign bus.w        = w_w;
    assign bus.readnum  = w_regnum;
    assign bus.writenum = w_regnum;
    assign bus.write    = w_write;
    assign bus.vsel     = w_vsel;
    assign bus.loada    = w_loada;
    assign bus.loadb    = w_loadb;
    assign bus.loadc    = w_loadc;
    assign bus.loads    = w_loads;
    assign bus.asel     = w_asel;
    assign bus.bsel     = w_bsel;
    assign bus.shift    = w_shift;
    assign bus.ALUop    = w_aluop;
    assign bus.sximm5   = w_sximm5;
    assign bus.sximm8   = w_sximm8;
endmodule
